id_decode_unit: RTL and testbench

- Instruction-decode (ID) stage datapath block of the 5-stage MIPS pipeline; sits between the IF/ID and ID/EX pipeline registers.
- Contains the 32x32 general-purpose register file, 16->32 sign extension, branch-target adder (PC+4 + sign-extended offset << 2) and an rs==rt comparator used for early branch resolution.
- Also splits opcode/funct fields for the main controller.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/id_decode_unit_if.sv | 34 +++
 rtl/id_regfile.sv | 60 ++++++
 rtl/id_decode_unit.sv | 44 ++++
 tb/tb_id_decode_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS ID stage: datapath widths and the
// bit positions of the instruction fields.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 2 ** REG_AW;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;

endpackage

// File: rtl/id_decode_unit_if.sv
// Bundle of the ID-stage signals: IF/ID and WB inputs going in,
// decoded fields, operands and branch information coming out.
interface id_decode_unit_if;
  import mips_pkg::*;

  logic                 reg_write;
  logic [DATA_W-1:0]    instruction;
  logic [DATA_W-1:0]    pc_plus4;
  logic [REG_AW-1:0]    write_reg;
  logic [DATA_W-1:0]    write_data;

  logic [DATA_W-1:0]    read_data1;
  logic [DATA_W-1:0]    read_data2;
  logic [DATA_W-1:0]    inst_extended;
  logic [DATA_W-1:0]    branch_target;
  logic [5:0]           opcode;
  logic [5:0]           func;
  logic                 zero;

  // The pipeline side drives instruction/WB inputs and observes results.
  modport master (
    output reg_write, instruction, pc_plus4, write_reg, write_data,
    input  read_data1, read_data2, inst_extended, branch_target,
           opcode, func, zero
  );

  // The decode unit consumes the inputs and produces the results.
  modport slave (
    input  reg_write, instruction, pc_plus4, write_reg, write_data,
    output read_data1, read_data2, inst_extended, branch_target,
           opcode, func, zero
  );

endinterface

// File: rtl/id_regfile.sv
// 32x32 general-purpose register file with asynchronous active-low clear,
// one write port, two asynchronous read ports and a write-through bypass
// so a value written back in WB is visible to ID in the same cycle.
module id_regfile
  import mips_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wrValid;

  // A write only counts when out of reset and not aimed at the hardwired R0;
  // the same qualifier gates the bypass so reset forces reads to zero.
  assign w_wrValid = i_rst_n && i_we && (i_waddr != '0);

  // Register array: cleared asynchronously by reset, written on rising clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrValid) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: R0 and reset read as zero, then bypass, then stored value.
  always_comb begin
    o_rdata1 = '0;
    if (!i_rst_n || (i_raddr1 == '0)) begin
      o_rdata1 = '0;
    end else if (w_wrValid && (i_waddr == i_raddr1)) begin
      o_rdata1 = i_wdata;
    end else begin
      o_rdata1 = r_regs[i_raddr1];
    end
  end

  // Read port 2: same priority as port 1, bypassing independently.
  always_comb begin
    o_rdata2 = '0;
    if (!i_rst_n || (i_raddr2 == '0)) begin
      o_rdata2 = '0;
    end else if (w_wrValid && (i_waddr == i_raddr2)) begin
      o_rdata2 = i_wdata;
    end else begin
      o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule

// File: rtl/id_decode_unit.sv
// MIPS ID stage: register file reads, immediate sign extension, branch
// target computation, rs==rt comparison for early branch resolution and
// opcode/funct split for the main controller. Purely combinational apart
// from the register file state.
module id_decode_unit
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  id_decode_unit_if.slave  bus
);

  logic [DATA_W-1:0] w_readData1;
  logic [DATA_W-1:0] w_readData2;
  logic [DATA_W-1:0] w_immExt;
  logic [DATA_W-1:0] w_branchOffset;

  id_regfile u_regfile (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_we     (bus.reg_write),
    .i_waddr  (bus.write_reg),
    .i_wdata  (bus.write_data),
    .i_raddr1 (bus.instruction[RS_HI:RS_LO]),
    .i_raddr2 (bus.instruction[RT_HI:RT_LO]),
    .o_rdata1 (w_readData1),
    .o_rdata2 (w_readData2)
  );

  // Sign-extended immediate and its word offset; the adder wraps silently.
  assign w_immExt       = {{(DATA_W-16){bus.instruction[IMM_HI]}},
                           bus.instruction[IMM_HI:IMM_LO]};
  assign w_branchOffset = {w_immExt[DATA_W-3:0], 2'b00};

  assign bus.read_data1    = w_readData1;
  assign bus.read_data2    = w_readData2;
  assign bus.inst_extended = w_immExt;
  assign bus.branch_target = bus.pc_plus4 + w_branchOffset;
  assign bus.opcode        = bus.instruction[OPCODE_HI:OPCODE_LO];
  assign bus.func          = bus.instruction[FUNCT_HI:FUNCT_LO];
  // Compare post-bypass operands so zero agrees with the data outputs.
  assign bus.zero          = (w_readData1 == w_readData2);

endmodule

// File: tb/tb_id_decode_unit.sv
// Self-checking bench for id_decode_unit: a table of decode vectors for the
// combinational field/immediate/branch logic plus directed register-file
// sequences for reset, writes, R0 protection and same-cycle bypass.
module tb_id_decode_unit;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] instruction;
    logic [31:0] pcPlus4;
    logic [31:0] expExt;
    logic [31:0] expTarget;
    logic [5:0]  expOpcode;
    logic [5:0]  expFunc;
  } decodeVec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  id_decode_unit_if bus();

  id_decode_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] makeInstr(input logic [5:0] op,
                                            input logic [4:0] rs,
                                            input logic [4:0] rt,
                                            input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic applyStimulus(input logic        regWrite,
                               input logic [4:0]  writeReg,
                               input logic [31:0] writeData,
                               input logic [31:0] instruction,
                               input logic [31:0] pcPlus4);
    bus.reg_write   = regWrite;
    bus.write_reg   = writeReg;
    bus.write_data  = writeData;
    bus.instruction = instruction;
    bus.pc_plus4    = pcPlus4;
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Write one register across a rising edge, then drop the enable.
  task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    applyStimulus(1'b1, addr, data, bus.instruction, bus.pc_plus4);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, bus.instruction, bus.pc_plus4);
  endtask

  decodeVec_t vecs[7];

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{32'h0000_8000, 32'h0000_1000, 32'hFFFF_8000, 32'hFFFE_1000, 6'h00, 6'h00};
    vecs[1] = '{32'h0000_0004, 32'h0000_1000, 32'h0000_0004, 32'h0000_1010, 6'h00, 6'h04};
    vecs[2] = '{32'h012A_4020, 32'h0000_1000, 32'h0000_4020, 32'h0001_1080, 6'h00, 6'h20};
    vecs[3] = '{32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0000, 6'h00, 6'h01};
    vecs[4] = '{32'h1109_FFFF, 32'h0040_0008, 32'hFFFF_FFFF, 32'h0040_0004, 6'h04, 6'h3F};
    vecs[5] = '{32'h8D2A_FFFC, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00F0, 6'h23, 6'h3C};
    vecs[6] = '{32'hFC00_7FFF, 32'h8000_0000, 32'h0000_7FFF, 32'h8001_FFFC, 6'h3F, 6'h3F};

    // Reset: reads are zero, zero flag set, decode still follows inputs.
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, makeInstr(6'h00, 5'd3, 5'd7, 16'h0004), 32'h0000_1000);
    #12;
    checkOutput("rst_rd1", bus.read_data1, 32'h0);
    checkOutput("rst_rd2", bus.read_data2, 32'h0);
    checkOutput("rst_zero", {31'h0, bus.zero}, 32'h1);
    checkOutput("rst_target", bus.branch_target, 32'h0000_1010);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_rd1", bus.read_data1, 32'h0);
    checkOutput("post_rst_zero", {31'h0, bus.zero}, 32'h1);

    // Write R8 and R9 on two edges, then read them together.
    writeReg(5'd8, 32'hDEAD_BEEF);
    writeReg(5'd9, 32'h0000_0001);
    applyStimulus(1'b0, 5'd0, 32'h0, makeInstr(6'h00, 5'd8, 5'd9, 16'h0), 32'h0);
    checkOutput("wr_rd1_r8", bus.read_data1, 32'hDEAD_BEEF);
    checkOutput("wr_rd2_r9", bus.read_data2, 32'h0000_0001);
    checkOutput("wr_zero", {31'h0, bus.zero}, 32'h0);

    // R0 protection: no bypass before the edge, nothing stored after it.
    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, makeInstr(6'h00, 5'd0, 5'd8, 16'h0), 32'h0);
    checkOutput("r0_no_bypass", bus.read_data1, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, makeInstr(6'h00, 5'd0, 5'd8, 16'h0), 32'h0);
    checkOutput("r0_reads_zero", bus.read_data1, 32'h0);

    // Disabled write to R3 must leave it alone and not bypass.
    writeReg(5'd3, 32'h0000_A5A5);
    @(negedge clk);
    applyStimulus(1'b0, 5'd3, 32'h0000_1111, makeInstr(6'h00, 5'd3, 5'd0, 16'h0), 32'h0);
    checkOutput("we0_no_bypass", bus.read_data1, 32'h0000_A5A5);
    @(posedge clk);
    #1;
    checkOutput("we0_r3_kept", bus.read_data1, 32'h0000_A5A5);

    // Bypass: both ports see the in-flight write before the edge.
    writeReg(5'd10, 32'h0000_0007);
    @(negedge clk);
    applyStimulus(1'b1, 5'd10, 32'h0000_0055, makeInstr(6'h00, 5'd10, 5'd10, 16'h0), 32'h0);
    checkOutput("byp_rd1", bus.read_data1, 32'h0000_0055);
    checkOutput("byp_rd2", bus.read_data2, 32'h0000_0055);
    checkOutput("byp_zero", {31'h0, bus.zero}, 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, makeInstr(6'h00, 5'd10, 5'd11, 16'h0), 32'h0);
    checkOutput("byp_stored_r10", bus.read_data1, 32'h0000_0055);
    checkOutput("r11_initial", bus.read_data2, 32'h0);

    // Independent bypass on rt only.
    @(negedge clk);
    applyStimulus(1'b1, 5'd11, 32'h0000_0077, makeInstr(6'h00, 5'd10, 5'd11, 16'h0), 32'h0);
    checkOutput("byp_rt_rd1", bus.read_data1, 32'h0000_0055);
    checkOutput("byp_rt_rd2", bus.read_data2, 32'h0000_0077);
    checkOutput("byp_rt_zero", {31'h0, bus.zero}, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, bus.instruction, 32'h0);

    // Mid-cycle reset clears stored data immediately and beats a write.
    writeReg(5'd5, 32'h0000_1234);
    applyStimulus(1'b0, 5'd0, 32'h0, makeInstr(6'h00, 5'd5, 5'd8, 16'h0), 32'h0);
    checkOutput("r5_written", bus.read_data1, 32'h0000_1234);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_r5", bus.read_data1, 32'h0);
    checkOutput("async_rst_r8", bus.read_data2, 32'h0);
    applyStimulus(1'b1, 5'd5, 32'h0000_0099, bus.instruction, 32'h0);
    checkOutput("rst_no_bypass", bus.read_data1, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'h0, bus.instruction, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rst_beats_write", bus.read_data1, 32'h0);

    // Table-driven decode vectors.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, vecs[i].instruction, vecs[i].pcPlus4);
      checkOutput($sformatf("ext_%0d", i), bus.inst_extended, vecs[i].expExt);
      checkOutput($sformatf("target_%0d", i), bus.branch_target, vecs[i].expTarget);
      checkOutput($sformatf("opcode_%0d", i), {26'h0, bus.opcode}, {26'h0, vecs[i].expOpcode});
      checkOutput($sformatf("func_%0d", i), {26'h0, bus.func}, {26'h0, vecs[i].expFunc});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
